// File: rtl/seq_add_sub_pkg.sv
// Shared definitions for the multi-cycle add/sub unit and future multi-cycle ALU units.
// State encodings are fixed 2-bit values so sibling units can share them.
package seq_add_sub_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_t;

    // Chunk counter width; a single-chunk unit still keeps a 1-bit counter.
    function automatic int cnt_width(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/seq_add_sub_if.sv
// Request/response bundle of the multi-cycle add/sub unit.
// The requester uses the master modport; the unit itself uses the slave modport.
interface seq_add_sub_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             borrow;
    logic             overflow;
    logic             zero;

    modport master (
        output start, sub, a, b,
        input  ready, done, result, carry_out, borrow, overflow, zero
    );

    modport slave (
        input  start, sub, a, b,
        output ready, done, result, carry_out, borrow, overflow, zero
    );

endinterface

// File: rtl/seq_add_sub_add_chunk.sv
// Combinational CHUNK-bit ripple adder built from gate-level full adders.
// msb_carry_in exposes the carry into the top bit so the caller can form signed overflow.
module add_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             carry_in,
    output logic [CHUNK-1:0] sum,
    output logic             carry_out,
    output logic             msb_carry_in
);

    logic [CHUNK:0] c;

    assign c[0] = carry_in;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        logic p;
        logic g;
        assign p        = a[i] ^ b[i];
        assign g        = a[i] & b[i];
        assign sum[i]   = p ^ c[i];
        assign c[i + 1] = g | (p & c[i]);
    end

    assign carry_out    = c[CHUNK];
    assign msb_carry_in = c[CHUNK - 1];

endmodule

// File: rtl/seq_add_sub.sv
// Multi-cycle WIDTH-bit adder/subtractor working CHUNK bits per clock, LSB chunk first.
//   state | meaning
//   IDLE  | waiting for start, ready=1
//   RUN   | one chunk per cycle, ready=0, outputs held
//   DONE  | done pulse with fresh result/flags, ready=1 so a new start is taken
module seq_add_sub
    import seq_add_sub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic         clk,
    input  logic         rst,
    seq_add_sub_if.slave bus
);

    localparam int             NCHUNK = WIDTH / CHUNK;
    localparam int             CW     = cnt_width(NCHUNK);
    localparam logic [CW-1:0]  LAST   = CW'(NCHUNK - 1);

    if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_bad_params
        $error("seq_add_sub: WIDTH (%0d) must be a non-zero multiple of CHUNK (%0d)", WIDTH, CHUNK);
    end

    state_t state;
    state_t state_nxt;
    logic   load;
    logic   step;
    logic   last;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nxt;
    logic             carry;
    logic             mode;
    logic [CW-1:0]    cnt;

    logic [CHUNK-1:0] a_chunks [NCHUNK];
    logic [CHUNK-1:0] b_chunks [NCHUNK];
    logic [CHUNK-1:0] a_k;
    logic [CHUNK-1:0] b_k;
    logic [CHUNK-1:0] sum_k;
    logic             co_k;
    logic             msb_ci_k;

    assign last = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        bus.ready = 1'b0;
        bus.done  = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        case (state)
            IDLE: begin
                bus.ready = 1'b1;
                if (bus.start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                bus.ready = 1'b1;
                bus.done  = 1'b1;
                if (bus.start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Chunk slicing and the accumulator update are unrolled per chunk so every
    // part-select is constant; only the final chunk pick depends on cnt.
    for (genvar g = 0; g < NCHUNK; g++) begin : g_slice
        assign a_chunks[g]                  = a_reg[g*CHUNK +: CHUNK];
        assign b_chunks[g]                  = b_reg[g*CHUNK +: CHUNK];
        assign acc_nxt[g*CHUNK +: CHUNK]    = (cnt == CW'(g)) ? sum_k : acc[g*CHUNK +: CHUNK];
    end

    if (NCHUNK == 1) begin : g_one_chunk
        assign a_k = a_chunks[0];
        assign b_k = b_chunks[0];
    end else begin : g_multi_chunk
        assign a_k = a_chunks[cnt];
        assign b_k = b_chunks[cnt];
    end

    add_chunk #(
        .CHUNK (CHUNK)
    ) u_add_chunk (
        .a            (a_k),
        .b            (b_k),
        .carry_in     (carry),
        .sum          (sum_k),
        .carry_out    (co_k),
        .msb_carry_in (msb_ci_k)
    );

    // Subtraction is a + ~b + 1: B is inverted at load and the +1 enters as the initial carry.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg         <= '0;
            b_reg         <= '0;
            acc           <= '0;
            carry         <= 1'b0;
            mode          <= 1'b0;
            cnt           <= '0;
            bus.result    <= '0;
            bus.carry_out <= 1'b0;
            bus.borrow    <= 1'b0;
            bus.overflow  <= 1'b0;
            bus.zero      <= 1'b0;
        end else if (load) begin
            a_reg <= bus.a;
            b_reg <= bus.sub ? ~bus.b : bus.b;
            carry <= bus.sub;
            mode  <= bus.sub;
            cnt   <= '0;
        end else if (step) begin
            acc   <= acc_nxt;
            carry <= co_k;
            cnt   <= cnt + CW'(1);
            if (last) begin
                bus.result    <= acc_nxt;
                bus.carry_out <= co_k;
                bus.overflow  <= co_k ^ msb_ci_k;
                bus.borrow    <= mode & ~co_k;
                bus.zero      <= (acc_nxt == '0);
            end
        end
    end

endmodule

// File: tb/tb_seq_add_sub.sv
// Scoreboard bench for seq_add_sub at 32/8, 16/16 and 64/4 with hand-computed vectors.
`timescale 1ns/1ps
module tb_seq_add_sub;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] res;
        logic        c;
        logic        bw;
        logic        ov;
        logic        z;
        int          due;
    } exp_t;

    exp_t        q32[$];
    exp_t        q16[$];
    exp_t        q64[$];
    logic [63:0] hold32 = '0;
    logic [63:0] hold16 = '0;
    logic [63:0] hold64 = '0;

    seq_add_sub_if #(.WIDTH(32)) b32 ();
    seq_add_sub_if #(.WIDTH(16)) b16 ();
    seq_add_sub_if #(.WIDTH(64)) b64 ();

    seq_add_sub #(.WIDTH(32), .CHUNK(8))  dut32 (.clk(clk), .rst(rst), .bus(b32));
    seq_add_sub #(.WIDTH(16), .CHUNK(16)) dut16 (.clk(clk), .rst(rst), .bus(b16));
    seq_add_sub #(.WIDTH(64), .CHUNK(4))  dut64 (.clk(clk), .rst(rst), .bus(b64));

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, expv);
        end
    endtask

    task automatic check_out(input string tag, input exp_t e, input logic [63:0] res,
                             input logic c, input logic bw, input logic ov, input logic z);
        chk({tag, "_latency"},   64'(cyc), 64'(e.due));
        chk({tag, "_result"},    res,      e.res);
        chk({tag, "_carry_out"}, 64'(c),   64'(e.c));
        chk({tag, "_borrow"},    64'(bw),  64'(e.bw));
        chk({tag, "_overflow"},  64'(ov),  64'(e.ov));
        chk({tag, "_zero"},      64'(z),   64'(e.z));
    endtask

    task automatic unexpected(input string tag);
        n_checks++;
        n_errors++;
        $display("FAIL %s_unexpected_done: got done=1 at cycle %0d, expected no done", tag, cyc);
    endtask

    // Monitors: sample 1 ns after each rising edge, pop on done, otherwise result must hold.
    always begin : mon32
        exp_t e;
        @(posedge clk); #1;
        if (b32.done) begin
            if (q32.size() == 0) unexpected("w32");
            else begin
                e = q32.pop_front();
                check_out("w32", e, 64'(b32.result), b32.carry_out, b32.borrow, b32.overflow, b32.zero);
                hold32 = e.res;
            end
        end else chk("w32_hold", 64'(b32.result), hold32);
    end

    always begin : mon16
        exp_t e;
        @(posedge clk); #1;
        if (b16.done) begin
            if (q16.size() == 0) unexpected("w16");
            else begin
                e = q16.pop_front();
                check_out("w16", e, 64'(b16.result), b16.carry_out, b16.borrow, b16.overflow, b16.zero);
                hold16 = e.res;
            end
        end else chk("w16_hold", 64'(b16.result), hold16);
    end

    always begin : mon64
        exp_t e;
        @(posedge clk); #1;
        if (b64.done) begin
            if (q64.size() == 0) unexpected("w64");
            else begin
                e = q64.pop_front();
                check_out("w64", e, b64.result, b64.carry_out, b64.borrow, b64.overflow, b64.zero);
                hold64 = e.res;
            end
        end else chk("w64_hold", b64.result, hold64);
    end

    task automatic ready_timeout(input string tag, input int n);
        n_checks++;
        n_errors++;
        $display("FAIL %s_ready_timeout: ready=0 for %0d cycles, expected 1", tag, n);
    endtask

    // Issue tasks are entered at a falling edge and return at a falling edge.
    task automatic issue32(input logic [31:0] a, input logic [31:0] b, input logic sub,
                           input logic [31:0] res, input logic c, input logic bw, input logic ov, input logic z);
        exp_t e;
        int   n;
        n = 0;
        while (!b32.ready && n < 100) begin @(negedge clk); n++; end
        if (!b32.ready) begin ready_timeout("w32", n); return; end
        b32.start = 1'b1; b32.a = a; b32.b = b; b32.sub = sub;
        @(posedge clk); #1;
        e.res = 64'(res); e.c = c; e.bw = bw; e.ov = ov; e.z = z; e.due = cyc + 4;
        q32.push_back(e);
        @(negedge clk);
        b32.start = 1'b0;
    endtask

    task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic sub,
                           input logic [15:0] res, input logic c, input logic bw, input logic ov, input logic z);
        exp_t e;
        int   n;
        n = 0;
        while (!b16.ready && n < 100) begin @(negedge clk); n++; end
        if (!b16.ready) begin ready_timeout("w16", n); return; end
        b16.start = 1'b1; b16.a = a; b16.b = b; b16.sub = sub;
        @(posedge clk); #1;
        e.res = 64'(res); e.c = c; e.bw = bw; e.ov = ov; e.z = z; e.due = cyc + 1;
        q16.push_back(e);
        @(negedge clk);
        b16.start = 1'b0;
    endtask

    task automatic issue64(input logic [63:0] a, input logic [63:0] b, input logic sub,
                           input logic [63:0] res, input logic c, input logic bw, input logic ov, input logic z);
        exp_t e;
        int   n;
        n = 0;
        while (!b64.ready && n < 100) begin @(negedge clk); n++; end
        if (!b64.ready) begin ready_timeout("w64", n); return; end
        b64.start = 1'b1; b64.a = a; b64.b = b; b64.sub = sub;
        @(posedge clk); #1;
        e.res = res; e.c = c; e.bw = bw; e.ov = ov; e.z = z; e.due = cyc + 16;
        q64.push_back(e);
        @(negedge clk);
        b64.start = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q32.size() + q16.size() + q64.size()) != 0 && n < 300) begin @(negedge clk); n++; end
        if ((q32.size() + q16.size() + q64.size()) != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0",
                     q32.size() + q16.size() + q64.size());
        end
    endtask

    task automatic assert_reset();
        rst    = 1'b1;
        hold32 = '0;
        hold16 = '0;
        hold64 = '0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        b32.start = 1'b0; b32.sub = 1'b0; b32.a = '0; b32.b = '0;
        b16.start = 1'b0; b16.sub = 1'b0; b16.a = '0; b16.b = '0;
        b64.start = 1'b0; b64.sub = 1'b0; b64.a = '0; b64.b = '0;
        assert_reset();
        repeat (3) @(negedge clk);
        chk("rst_ready",     64'(b32.ready),     64'd1);
        chk("rst_done",      64'(b32.done),      64'd0);
        chk("rst_result",    64'(b32.result),    64'd0);
        chk("rst_carry_out", 64'(b32.carry_out), 64'd0);
        chk("rst_borrow",    64'(b32.borrow),    64'd0);
        chk("rst_overflow",  64'(b32.overflow),  64'd0);
        chk("rst_zero",      64'(b32.zero),      64'd0);
        chk("rst_ready16",   64'(b16.ready),     64'd1);
        chk("rst_ready64",   64'(b64.ready),     64'd1);
        rst = 1'b0;
        @(negedge clk);

        //       a              b              sub   result         c     bw    ov    z
        issue32(32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("w32_ready_in_run", 64'(b32.ready), 64'd0);
        issue32(32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0, 1'b0);
        issue32(32'h0000_0007, 32'h0000_0007, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1);
        issue32(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b0);
        issue32(32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0);
        issue32(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1);
        issue32(32'h1234_5678, 32'h0FED_CBA9, 1'b0, 32'h2222_2221, 1'b0, 1'b0, 1'b0, 1'b0);
        issue32(32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1);
        issue32(32'h0000_0000, 32'h8000_0000, 1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b0);

        // A start pulsed while RUN must not disturb the operation in flight.
        issue32(32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("w32_ready_in_run2", 64'(b32.ready), 64'd0);
        b32.start = 1'b1; b32.a = 32'h0000_0001; b32.b = 32'h0000_0001; b32.sub = 1'b1;
        @(negedge clk);
        b32.start = 1'b0;
        drain();

        // Reset in the second RUN cycle: back to IDLE, outputs cleared, no done.
        b32.start = 1'b1; b32.a = 32'h0000_00FF; b32.b = 32'h0000_0001; b32.sub = 1'b0;
        @(negedge clk);
        b32.start = 1'b0;
        @(negedge clk);
        assert_reset();
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_ready",  64'(b32.ready),  64'd1);
        chk("midrst_result", 64'(b32.result), 64'd0);
        chk("midrst_done",   64'(b32.done),   64'd0);
        repeat (8) @(negedge clk);

        // Reset and start together: reset wins, unit stays idle.
        b32.start = 1'b1; b32.a = 32'h0000_0003; b32.b = 32'h0000_0004; b32.sub = 1'b0;
        assert_reset();
        @(negedge clk);
        rst = 1'b0;
        b32.start = 1'b0;
        chk("rst_start_ready", 64'(b32.ready), 64'd1);
        repeat (8) @(negedge clk);

        issue32(32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b0);

        issue16(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b0);
        issue16(16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b1, 1'b0, 1'b0);
        issue16(16'h8000, 16'h8000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
        issue16(16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b0);

        issue64(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        issue64(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b1, 1'b0);
        issue64(64'h0000_0001_0000_0000, 64'h1, 1'b1, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0);
        issue64(64'h0, 64'h1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0);

        drain();
        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
